si_bus_arbiter: RTL

Round-robin arbiter that shares the single system-interface (SI) write/read port between NREQ driver blocks. Each driver holds its exec request with address/data/we until it receives its own fin pulse. The arbiter selects one requester, forwards one transaction to the SI target, waits for the target's fin, and returns fin to the winner. It sits between the driver blocks and the SI target.

---
 rtl/si_bus_arbiter_if.sv | 47 ++++
 rtl/si_bus_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/si_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// si_bus_arbiter_if
//   Bundles the requester-side and SI-target-side signals of si_bus_arbiter.
//
//   Requester side : req_exec, req_we, req_address, req_data (to arbiter)
//                    req_fin, req_err                        (from arbiter)
//   SI target side : si_exec, si_we, si_address, si_data     (from arbiter)
//                    si_fin                                  (to arbiter)
//   Status         : grant_id, busy                          (from arbiter)
//
//   Modports:
//     slave  - the arbiter itself
//     master - the surroundings (driver blocks + SI target, or a testbench)
// -----------------------------------------------------------------------------
interface si_bus_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]    req_exec;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_address;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_fin;
  logic               req_err;
  logic               si_exec;
  logic               si_we;
  logic [AW-1:0]      si_address;
  logic [DW-1:0]      si_data;
  logic               si_fin;
  logic [GW-1:0]      grant_id;
  logic               busy;

  modport slave (
    input  req_exec, req_we, req_address, req_data, si_fin,
    output req_fin, req_err, si_exec, si_we, si_address, si_data,
           grant_id, busy
  );

  modport master (
    output req_exec, req_we, req_address, req_data, si_fin,
    input  req_fin, req_err, si_exec, si_we, si_address, si_data,
           grant_id, busy
  );
endinterface

// File: rtl/si_bus_arbiter.sv
// -----------------------------------------------------------------------------
// si_bus_arbiter
//   Round-robin arbiter sharing one SI write/read port between NREQ driver
//   blocks. A winner is picked in IDLE, its we/address/data are latched and a
//   single si_exec pulse is issued; when the target answers with si_fin the
//   winner gets a one-cycle req_fin pulse, then one GAP cycle lets it drop
//   req_exec before the next arbitration. All outputs are registered.
//
//   Ports:
//     clk    - system clock, rising edge
//     nreset - asynchronous active-low reset
//     bus    - si_bus_arbiter_if.slave (requester + SI target signals)
//
//   Optional feature (macro SI_ARB_TIMEOUT_EN):
//     A 16-bit WAIT watchdog; after TIMEOUT WAIT cycles without si_fin the
//     transaction completes with req_err=1. Without the macro no counter is
//     built and req_err is constantly 0.
// -----------------------------------------------------------------------------
module si_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             nreset,
  si_bus_arbiter_if.slave  bus
);
  localparam int GW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, GAP} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic            si_exec_q, si_exec_d;
  logic            si_we_q, si_we_d;
  logic [AW-1:0]   si_address_q, si_address_d;
  logic [DW-1:0]   si_data_q, si_data_d;
  logic [NREQ-1:0] req_fin_q, req_fin_d;
  logic            req_err_q, req_err_d;
  logic            busy_q, busy_d;

`ifdef SI_ARB_TIMEOUT_EN
  logic [15:0]     wait_cnt_q, wait_cnt_d;
`else
  // TIMEOUT only matters when the watchdog is built.
  localparam int unused_timeout = TIMEOUT;
`endif

  // Round-robin pick: first requesting index above last_grant, wrapping.
  logic            winner_found;
  logic [GW-1:0]   winner_idx;

  always_comb begin
    winner_found = 1'b0;
    winner_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      int idx;
      idx = (int'(last_grant_q) + i) % NREQ;
      if (!winner_found && bus.req_exec[GW'(idx)]) begin
        winner_found = 1'b1;
        winner_idx   = GW'(idx);
      end
    end
  end

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    si_exec_d    = 1'b0;
    si_we_d      = si_we_q;
    si_address_d = si_address_q;
    si_data_d    = si_data_q;
    req_fin_d    = '0;
    req_err_d    = 1'b0;
`ifdef SI_ARB_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (winner_found) begin
          grant_id_d   = winner_idx;
          si_we_d      = bus.req_we[winner_idx];
          si_address_d = AW'(bus.req_address >> (int'(winner_idx) * AW));
          si_data_d    = DW'(bus.req_data >> (int'(winner_idx) * DW));
          si_exec_d    = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
`ifdef SI_ARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        // si_fin wins over a simultaneous timeout, so err stays 0 then.
        if (bus.si_fin) begin
          req_fin_d = NREQ'(1) << grant_id_q;
          state_d   = DONE;
        end
`ifdef SI_ARB_TIMEOUT_EN
        else if (wait_cnt_q == 16'(TIMEOUT - 1)) begin
          req_fin_d = NREQ'(1) << grant_id_q;
          req_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
`endif
      end
      DONE: begin
        last_grant_d = grant_id_q;
        state_d      = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its _d, independent of statement order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NREQ - 1);
      si_exec_q    <= 1'b0;
      si_we_q      <= 1'b0;
      si_address_q <= '0;
      si_data_q    <= '0;
      req_fin_q    <= '0;
      req_err_q    <= 1'b0;
      busy_q       <= 1'b0;
`ifdef SI_ARB_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      si_exec_q    <= si_exec_d;
      si_we_q      <= si_we_d;
      si_address_q <= si_address_d;
      si_data_q    <= si_data_d;
      req_fin_q    <= req_fin_d;
      req_err_q    <= req_err_d;
      busy_q       <= busy_d;
`ifdef SI_ARB_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  assign bus.req_fin    = req_fin_q;
  assign bus.req_err    = req_err_q;
  assign bus.si_exec    = si_exec_q;
  assign bus.si_we      = si_we_q;
  assign bus.si_address = si_address_q;
  assign bus.si_data    = si_data_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = busy_q;
endmodule
